// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared definitions for the instruction-memory loader.
//               Holds the memory geometry, the instruction width and the
//               loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int IMEM_DEPTH  = 101;  // instruction memory depth in words
    localparam int IMEM_ADDR_W = 7;    // word-index width, 2^7 >= 101
    localparam int INSTR_W     = 32;   // instruction word width

    // Loader FSM states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_BODY = 3'd2,
        S_WR   = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } loader_state_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Assembles big-endian 32-bit words from a byte stream.
//               The first byte of a group of four lands in bits [31:24].
// Ports       : clk       - clock
//               rst       - synchronous active-high reset
//               clear     - restart the byte group (entry to header phase)
//               load      - a byte is accepted this cycle
//               in_byte   - byte to shift in
//               word      - shift register contents (registered)
//               word_full - high in the cycle the 4th byte of a group is
//                           accepted (combinational, feeds next-state only)
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import imem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic [7:0]         in_byte,
    output logic [INSTR_W-1:0] word,
    output logic               word_full
);

    logic [1:0]         r_cnt;
    logic [INSTR_W-1:0] r_word;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt  <= 2'd0;
            r_word <= '0;
        end else if (load) begin
            // The 2-bit counter wraps naturally after the 4th byte.
            r_cnt  <= r_cnt + 2'd1;
            r_word <= {r_word[INSTR_W-9:0], in_byte};
        end
    end

    assign word      = r_word;
    assign word_full = load && (r_cnt == 2'd3);

endmodule : byte_packer
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Receives a program image as a byte stream (valid/ready),
//               assembles big-endian 32-bit words and writes them to
//               instruction memory at word indices 0..N-1. The processor is
//               held in reset (cpu_hold) until a load completes.
//               Frame: length word N, N instruction words, and - when the
//               LOADER_CHECKSUM_EN macro is defined - a trailing checksum
//               word equal to the mod-2^32 sum of the N words.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start             - begins a load from IDLE/DONE/ERR
//               in_valid/in_byte  - byte stream input
//               in_ready          - byte accepted when in_valid && in_ready
//               we/waddr/wdata    - instruction memory write port
//               cpu_hold          - processor reset request
//               done/error        - load outcome levels
//               words_loaded      - words written in the current load
// Config      : LOADER_CHECKSUM_EN - enables checksum phase and sum logic
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    output logic               in_ready,
    output logic               we,
    output logic [ADDR_W-1:0]  waddr,
    output logic [INSTR_W-1:0] wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    words_loaded
);

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic [ADDR_W:0]    r_words;
    logic [ADDR_W:0]    r_len;
    logic [ADDR_W:0]    w_words_inc;
    logic               w_start_ok;
    logic               w_accept;
    logic [INSTR_W-1:0] w_word;
    logic               w_word_full;
    logic [INSTR_W-1:0] w_full_word;

`ifdef LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] r_sum;
`endif

    // start only has effect where a new load may begin.
    assign w_start_ok  = start && ((r_state == S_IDLE) ||
                                   (r_state == S_DONE) ||
                                   (r_state == S_ERR));
    assign w_accept    = in_valid && in_ready;
    assign w_words_inc = r_words + (ADDR_W+1)'(1);

    // Value of the word being completed on this edge: the three bytes
    // already in the packer plus the byte currently on the bus.
    assign w_full_word = {w_word[INSTR_W-9:0], in_byte};

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_start_ok),
        .load      (w_accept),
        .in_byte   (in_byte),
        .word      (w_word),
        .word_full (w_word_full)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode (outputs depend on r_state only)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        cpu_hold    = 1'b1;
        done        = 1'b0;
        error       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nxt = S_HDR;
            end

            S_HDR: begin
                in_ready = 1'b1;
                if (w_word_full) begin
                    // Full 32-bit unsigned compare so huge lengths are rejected.
                    if (w_full_word > INSTR_W'(DEPTH)) begin
                        w_state_nxt = S_ERR;
                    end else if (w_full_word == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        w_state_nxt = S_CHK;
`else
                        w_state_nxt = S_DONE;
`endif
                    end else begin
                        w_state_nxt = S_BODY;
                    end
                end
            end

            S_BODY: begin
                in_ready = 1'b1;
                if (w_word_full) w_state_nxt = S_WR;
            end

            S_WR: begin
                we    = 1'b1;
                waddr = r_words[ADDR_W-1:0];
                wdata = w_word;
                if (w_words_inc < r_len) begin
                    w_state_nxt = S_BODY;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_nxt = S_CHK;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                if (w_word_full) begin
                    w_state_nxt = (w_full_word == r_sum) ? S_DONE : S_ERR;
                end
            end
`endif

            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (w_start_ok) w_state_nxt = S_HDR;
            end

            S_ERR: begin
                error = 1'b1;
                if (w_start_ok) w_state_nxt = S_HDR;
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length, word count and running sum
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_words <= '0;
            r_len   <= '0;
        end else begin
            // Only a length that passed the range check is kept, so it
            // always fits in ADDR_W+1 bits.
            if ((r_state == S_HDR) && w_word_full &&
                (w_full_word <= INSTR_W'(DEPTH))) begin
                r_len <= w_full_word[ADDR_W:0];
            end
            if (r_state == S_WR) begin
                r_words <= w_words_inc;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_sum <= '0;
        end else if (r_state == S_WR) begin
            r_sum <= r_sum + w_word;
        end
    end
`endif

    assign words_loaded = r_words;

endmodule : instr_mem_loader
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Self-checking bench for instr_mem_loader. Expected writes
//               are queued as each word is streamed and compared when the
//               loader strobes we. Follows LOADER_CHECKSUM_EN for framing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;
    import imem_pkg::*;

    localparam int AW = IMEM_ADDR_W;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           in_valid;
    logic [7:0]     in_byte;
    logic           in_ready;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [31:0]    wdata;
    logic           cpu_hold;
    logic           done;
    logic           error;
    logic [AW:0]    words_loaded;

    always #5 clk = ~clk;

    instr_mem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[$];
    int          checks = 0;
    int          passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    // Write monitor: every we pulse must match the head of the scoreboard.
    wr_t mon_e;
    always @(negedge clk) begin
        if (we === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) begin
                passed++;
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(waddr), 32'(mon_e.addr));
                check("wr_data", wdata, mon_e.data);
                check("wr_ready_low", 32'(in_ready), 32'd0);
            end else $error("FAIL unexpected_we: observed waddr=%0d wdata=0x%08h required no write",
                            waddr, wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int guard = 0;
        if (stall) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard < 50) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        assert (guard < 50) passed++;
        else $error("FAIL send_byte_timeout: observed no in_ready for 50 cycles, required in_ready=1");
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        send_byte(w[31:24], stall);
        send_byte(w[23:16], stall);
        send_byte(w[15:8],  stall);
        send_byte(w[7:0],   stall);
    endtask

    // Streams length, img contents and (if enabled) checksum, queueing writes.
    task automatic send_frame(input bit stall, input bit bad_csum);
        logic [31:0] sum = 32'd0;
        send_word(32'(img.size()), stall);
        for (int i = 0; i < img.size(); i++) begin
            exp_q.push_back('{addr: i[AW-1:0], data: img[i]});
            sum += img[i];
            send_word(img[i], stall);
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(bad_csum ? 32'h0 : sum, stall);
`else
        if (bad_csum) sum = 32'h0;
`endif
    endtask

    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_hold"},  32'(cpu_hold), 32'd1);
        check({tag, "_done"},  32'(done),     32'd0);
    endtask

    task automatic wait_end(input string tag);
        int g = 0;
        while (!(done === 1'b1 || error === 1'b1) && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        checks++;
        assert (g < 40) passed++;
        else $error("FAIL %s_timeout: observed no done/error in 40 cycles, required done or error", tag);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready),     32'd0);
        check({tag, "_we"},       32'(we),           32'd0);
        check({tag, "_waddr"},    32'(waddr),        32'd0);
        check({tag, "_wdata"},    wdata,             32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd1);
        check({tag, "_done"},     32'(done),         32'd0);
        check({tag, "_error"},    32'(error),        32'd0);
        check({tag, "_words"},    32'(words_loaded), 32'd0);
    endtask

    task automatic check_done(input string tag, input int n);
        check({tag, "_done"},  32'(done),         32'd1);
        check({tag, "_error"}, 32'(error),        32'd0);
        check({tag, "_hold"},  32'(cpu_hold),     32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'(n));
        check({tag, "_q"},     32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_basic();
        img.delete();
        img.push_back(32'h20080005);
        img.push_back(32'h8D090004);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 32'(in_ready), 32'd0);

        // Basic two-word load.
        set_basic();
        pulse_start("basic_start");
        send_frame(1'b0, 1'b0);
        wait_end("basic");
        check_done("basic", 2);

        // Reload from DONE with random in_valid gaps.
        pulse_start("stall_start");
        send_frame(1'b1, 1'b0);
        wait_end("stall");
        check_done("stall", 2);

        // Oversize length: error after the length word, no writes.
        pulse_start("over_start");
        send_word(32'h00000066, 1'b0);
        check("over_error", 32'(error),        32'd1);
        check("over_hold",  32'(cpu_hold),     32'd1);
        check("over_done",  32'(done),         32'd0);
        check("over_ready", 32'(in_ready),     32'd0);
        check("over_words", 32'(words_loaded), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("over_stay",  32'(error),        32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: writes happen, then error.
        set_basic();
        pulse_start("csum_start");
        send_frame(1'b0, 1'b1);
        wait_end("csum");
        check("csum_error", 32'(error),        32'd1);
        check("csum_done",  32'(done),         32'd0);
        check("csum_hold",  32'(cpu_hold),     32'd1);
        check("csum_words", 32'(words_loaded), 32'd2);
`endif

        // Reset mid-word, with start held high to show rst wins.
        set_basic();
        pulse_start("rstmid_start");
        send_word(32'd2, 1'b0);
        exp_q.push_back('{addr: '0, data: img[0]});
        send_word(img[0], 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        check_reset("rstmid");
        check("rstmid_q", 32'(exp_q.size()), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        img.delete();
        img.push_back(32'hCAFEF00D);
        img.push_back(32'h01234567);
        img.push_back(32'hFFFFFFFF);
        pulse_start("fresh_start");
        send_frame(1'b0, 1'b0);
        wait_end("fresh");
        check_done("fresh", 3);

        // Full depth: last write lands at index DEPTH-1.
        img.delete();
        for (int i = 0; i < IMEM_DEPTH; i++) img.push_back($urandom);
        pulse_start("full_start");
        send_frame(1'b0, 1'b0);
        wait_end("full");
        check_done("full", IMEM_DEPTH);

        // Zero length, then reload from DONE.
        img.delete();
        pulse_start("zero_start");
        send_frame(1'b0, 1'b0);
        wait_end("zero");
        check_done("zero", 0);
        img.push_back(32'h0BADBEEF);
        pulse_start("reload_start");
        send_frame(1'b0, 1'b0);
        wait_end("reload");
        check_done("reload", 1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_instr_mem_loader
`default_nettype wire

// File: doc/instr_mem_loader.md
# instr_mem_loader

Write-side counterpart of the instruction fetch path: receives a program image as a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them into instruction memory at word indices 0..N-1. While loading, it holds the processor in reset via `cpu_hold`, so fetch only reads memory contents that have been fully written. The block sits between the test/boot interface and the instruction memory write port.

## Interface
- `DEPTH`, 101: instruction memory depth in words; valid word indices are 0..DEPTH-1.
- `ADDR_W`, 7: word-index width; requires 2^ADDR_W ≥ DEPTH.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a load from IDLE, DONE or ERROR.
- `in_valid`  in  1  `in_byte` is valid.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `we`  out  1  instruction memory write strobe, one cycle per word.
- `waddr`  out  ADDR_W  word index for the write.
- `wdata`  out  32  instruction word for the write.
- `cpu_hold`  out  1  processor reset request.
- `done`  out  1  load completed successfully (level).
- `error`  out  1  load aborted (level).
- `words_loaded`  out  ADDR_W+1  count of words written in the current load.

## Operation
- **Byte transfer:** a byte is accepted on a rising edge where `in_valid && in_ready`. Bytes are taken MSB first; the first accepted byte of a group of 4 becomes bits [31:24].
- **Frame format:** a 4-byte length word N, then N instruction words, then (with checksum enabled) a 4-byte checksum.
- **States:** IDLE, HDR, BODY, WR, CHK, DONE, ERR.
- **IDLE:** `in_ready`=0, `cpu_hold`=1. A `start` pulse moves to HDR and clears `words_loaded`, `done`, `error` and the running sum.
- **HDR:** `in_ready`=1. After the 4th byte:
  - N > DEPTH → ERR.
  - N = 0 → CHK (checksum enabled) or DONE.
  - Otherwise → BODY.
- **BODY:** `in_ready`=1. After the 4th byte → WR.
- **WR:** lasts exactly one cycle.
  - `we`=1, `waddr`=`words_loaded[ADDR_W-1:0]`, `wdata`=assembled word, `in_ready`=0.
  - On exit: `words_loaded` increments and the word is added to the sum.
  - Then → BODY if `words_loaded`+1 < N, otherwise → CHK or DONE.
- **CHK:** `in_ready`=1. After 4 bytes, compare the received value with the sum (mod 2^32) of all N words. Match → DONE; mismatch → ERR.
- **DONE:** `done`=1, `cpu_hold`=0, `in_ready`=0.
- **ERR:** `error`=1, `cpu_hold`=1, `in_ready`=0.
- **Leaving DONE/ERR:** only `start` (→ HDR, `cpu_hold` back to 1) or `rst`.
- **`start` in HDR/BODY/WR/CHK:** ignored.
- **Arithmetic:** N is compared as a full 32-bit unsigned value. `waddr` never reaches DEPTH.

## Timing
- **Reset values:** `in_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, `words_loaded`=0; state IDLE; byte counter and sum cleared.
- **All outputs registered** or decoded from registered state only; no combinational path from `in_valid` to `in_ready`.
- **`start` → first ready:** `start` in cycle t gives `in_ready`=1 in cycle t+1.
- **Write latency:** the 4th byte of a word accepted at edge t gives `we`=1 in the cycle following t. The next byte can be accepted one cycle later.
- **Throughput:** maximum 5 cycles per word (4 byte cycles + 1 write cycle).
- **Stalls:** `in_valid` gaps stall the byte counter; partial words are retained indefinitely.
- **`rst` mid-load:** returns to the reset values on the next edge. Memory contents already written are left as-is; the partial word is discarded.
- **`rst` and `start` together:** `rst` wins.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:** CHK state present; trailing checksum word required; mismatch → ERR.
- **Not defined:** CHK and the sum logic are removed. After the last WR (or N=0), go straight to DONE; the frame is the length word plus N words only.

## Structure
- **Shared package `imem_pkg`:**
  - state enum `loader_state_t`;
  - `IMEM_DEPTH`=101;
  - `IMEM_ADDR_W`=7;
  - `INSTR_W`=32.
- **Sub-module `byte_packer`:** 2-bit byte counter plus a 32-bit shift register. Signals: `load` in, `clear` in, `word` out, `word_full` out (pulse on the 4th byte). Instantiated once; its counter is cleared on entry to HDR and on `rst`.

## Test plan
- **Basic load:** `start`, stream 00 00 00 02, 20 08 00 05, 8D 09 00 04 (plus checksum AD 11 00 09 if enabled). Expected: two `we` pulses with (0, 0x20080005) and (1, 0x8D090004), then `done`=1, `cpu_hold`=0, `words_loaded`=2.
- **Oversize length:** length 0x00000066 (102). Expected: ERR after the 4th byte, `error`=1, no `we`, `cpu_hold`=1.
- **Bad checksum (`LOADER_CHECKSUM_EN`):** basic image with checksum 0. Expected: both writes occur, then `error`=1, `done`=0.
- **Stalls:** random `in_valid` gaps during the basic load. Expected: identical writes and ordering; `in_ready` never high in WR.
- **Reset mid-word:** `rst` after 2 bytes of word 1. Expected: all reset values next cycle; a fresh `start` plus a full image loads correctly from index 0.
- **Zero-length and reload:** N=0 → `done` with no writes. Then `start` from DONE → `cpu_hold`=1 next cycle, and a new image loads.
